// File: rtl/int_bus_arbiter_if.sv
// Internal memory bus arbiter interface: requester side, granted-owner outputs and shared bus.
// master is the arbiter's view; slave is the view of requesters plus the memory bus.
interface int_bus_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic                     bus_busy;
  logic [NREQ-1:0]          req;
  logic [NREQ-1:0]          we;
  logic [NREQ*ADDR_W-1:0]   addr_i;
  logic [NREQ*DATA_W-1:0]   wdata_i;
  logic [NREQ-1:0]          grant;
  logic [NREQ-1:0]          done;
  logic [DATA_W-1:0]        rdata;
  logic                     err;
  logic [ADDR_W-1:0]        addr_out;
  logic [DATA_W-1:0]        data_out;
  logic                     read_q;
  logic                     write_q;
  logic [DATA_W-1:0]        data_in;
  logic                     read_dn;
  logic                     write_dn;

  modport master (
    input  bus_busy, req, we, addr_i, wdata_i, data_in, read_dn, write_dn,
    output grant, done, rdata, err, addr_out, data_out, read_q, write_q
  );

  modport slave (
    output bus_busy, req, we, addr_i, wdata_i, data_in, read_dn, write_dn,
    input  grant, done, rdata, err, addr_out, data_out, read_q, write_q
  );

endinterface

// File: rtl/int_bus_arbiter.sv
// Round-robin arbiter sequencing one transfer at a time onto the shared internal memory bus.
// Optional handshake timeout enabled by defining INT_BUS_ARB_TIMEOUT_EN.
module int_bus_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  int_bus_arbiter_if.master   bus
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] owner;
  logic             is_write;

  logic             win_valid_c;
  logic [IDX_W-1:0] win_idx_c;
  logic [IDX_W-1:0] cand_c;
  logic             hs_c;
  logic             timeout_c;

  // Round-robin pick: first set req bit scanning upward from last+1; descending loop so the nearest wins.
  always_comb begin
    win_valid_c = 1'b0;
    win_idx_c   = '0;
    cand_c      = '0;
    for (int i = int'(NREQ); i >= 1; i--) begin
      cand_c = IDX_W'((int'(last) + i) % int'(NREQ));
      if (bus.req[cand_c]) begin
        win_valid_c = 1'b1;
        win_idx_c   = cand_c;
      end
    end
  end

  // Only the handshake matching the latched direction completes a transfer.
  assign hs_c = is_write ? bus.write_dn : bus.read_dn;

`ifdef INT_BUS_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = (TO_CYCLES > 255) ? 16 : 8;

  logic [TO_W-1:0] to_cnt;

  // Counts XFER cycles; held at zero outside XFER so it starts fresh on every entry.
  always_ff @(posedge clk) begin
    if (rst || (state != XFER)) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign timeout_c = (to_cnt == TO_W'(TO_CYCLES - 1));
`else
  localparam int unsigned unused_to_cycles = TO_CYCLES;

  assign timeout_c = 1'b0;
  assign bus.err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last         <= IDX_W'(NREQ - 1);
      owner        <= '0;
      is_write     <= 1'b0;
      bus.grant    <= '0;
      bus.done     <= '0;
      bus.rdata    <= '0;
      bus.addr_out <= '0;
      bus.data_out <= '0;
      bus.read_q   <= 1'b0;
      bus.write_q  <= 1'b0;
`ifdef INT_BUS_ARB_TIMEOUT_EN
      bus.err      <= 1'b0;
`endif
    end else begin
      bus.done <= '0;
`ifdef INT_BUS_ARB_TIMEOUT_EN
      bus.err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!bus.bus_busy && win_valid_c) begin
            owner        <= win_idx_c;
            is_write     <= bus.we[win_idx_c];
            bus.grant    <= NREQ'(1'b1) << win_idx_c;
            bus.addr_out <= bus.addr_i[int'(win_idx_c) * int'(ADDR_W) +: ADDR_W];
            bus.data_out <= bus.we[win_idx_c] ?
                            bus.wdata_i[int'(win_idx_c) * int'(DATA_W) +: DATA_W] : '0;
            bus.read_q   <= ~bus.we[win_idx_c];
            bus.write_q  <= bus.we[win_idx_c];
            state        <= XFER;
          end
        end
        XFER: begin
          // A handshake coincident with the timeout completes normally.
          if (hs_c || timeout_c) begin
            bus.done     <= bus.grant;
            bus.grant    <= '0;
            bus.addr_out <= '0;
            bus.data_out <= '0;
            bus.read_q   <= 1'b0;
            bus.write_q  <= 1'b0;
            if (hs_c && !is_write) begin
              bus.rdata <= bus.data_in;
            end
`ifdef INT_BUS_ARB_TIMEOUT_EN
            bus.err      <= ~hs_c;
`endif
            last         <= owner;
            state        <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_bus_arbiter.sv
// Directed self-checking bench for int_bus_arbiter; timeout scenario runs when INT_BUS_ARB_TIMEOUT_EN is defined.
module tb_int_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] exp_rdata;

  int_bus_arbiter_if #(.NREQ(4), .ADDR_W(32), .DATA_W(32)) bus ();

  int_bus_arbiter #(
    .NREQ(4), .ADDR_W(32), .DATA_W(32), .TO_CYCLES(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.bus_busy = 1'b0;
    bus.req      = '0;
    bus.we       = '0;
    bus.addr_i   = '0;
    bus.wdata_i  = '0;
    bus.data_in  = '0;
    bus.read_dn  = 1'b0;
    bus.write_dn = 1'b0;
    do_reset();
    n_cmp++; if (bus.grant !== 4'b0000 || bus.done !== 4'b0000) begin n_bad++;
      $display("FAIL reset_grant_done: got grant=%b done=%b want 0000/0000", bus.grant, bus.done); end
    n_cmp++; if (bus.read_q !== 1'b0 || bus.write_q !== 1'b0 || bus.err !== 1'b0) begin n_bad++;
      $display("FAIL reset_strobes: got rq=%b wq=%b err=%b want 0/0/0", bus.read_q, bus.write_q, bus.err); end
    n_cmp++; if (bus.addr_out !== 32'h0 || bus.data_out !== 32'h0 || bus.rdata !== 32'h0) begin n_bad++;
      $display("FAIL reset_buses: got addr=%h data=%h rdata=%h want zeros", bus.addr_out, bus.data_out, bus.rdata); end
  endtask

  task automatic test_single_read();
    bus.addr_i[0 +: 32] = 32'h0000_0100;
    bus.data_in = 32'hDEAD_BEEF;
    bus.we  = 4'b0000;
    bus.req = 4'b0001;
    tick();
    n_cmp++; if (bus.read_q !== 1'b1 || bus.write_q !== 1'b0 || bus.grant !== 4'b0001) begin n_bad++;
      $display("FAIL rd_start: got rq=%b wq=%b grant=%b want 1/0/0001", bus.read_q, bus.write_q, bus.grant); end
    n_cmp++; if (bus.addr_out !== 32'h100 || bus.data_out !== 32'h0) begin n_bad++;
      $display("FAIL rd_addr: got addr=%h data=%h want 100/0", bus.addr_out, bus.data_out); end
    tick();
    tick();
    n_cmp++; if (bus.read_q !== 1'b1 || bus.done !== 4'b0000) begin n_bad++;
      $display("FAIL rd_hold: got rq=%b done=%b want 1/0000", bus.read_q, bus.done); end
    bus.read_dn = 1'b1;
    tick();
    bus.read_dn = 1'b0;
    bus.req     = 4'b0000;
    exp_rdata   = 32'hDEAD_BEEF;
    n_cmp++; if (bus.done !== 4'b0001 || bus.rdata !== exp_rdata || bus.err !== 1'b0) begin n_bad++;
      $display("FAIL rd_done: got done=%b rdata=%h err=%b want 0001/%h/0", bus.done, bus.rdata, bus.err, exp_rdata); end
    n_cmp++; if (bus.read_q !== 1'b0 || bus.grant !== 4'b0000 || bus.addr_out !== 32'h0) begin n_bad++;
      $display("FAIL rd_release: got rq=%b grant=%b addr=%h want 0/0000/0", bus.read_q, bus.grant, bus.addr_out); end
    bus.data_in = 32'h1111_2222;
    tick();
    n_cmp++; if (bus.done !== 4'b0000 || bus.read_q !== 1'b0 || bus.rdata !== exp_rdata) begin n_bad++;
      $display("FAIL rd_turnaround: got done=%b rq=%b rdata=%h want 0000/0/%h", bus.done, bus.read_q, bus.rdata, exp_rdata); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] order [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100; order[3] = 4'b1000; order[4] = 4'b0001;
    do_reset();
    exp_rdata = 32'h0;
    bus.we  = 4'b0000;
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      bus.data_in = 32'hA000_0000 + 32'(i);
      tick();
      n_cmp++; if (bus.grant !== order[i] || bus.read_q !== 1'b1) begin n_bad++;
        $display("FAIL rr_grant%0d: got grant=%b rq=%b want %b/1", i, bus.grant, bus.read_q, order[i]); end
      bus.read_dn = 1'b1;
      tick();
      bus.read_dn = 1'b0;
      n_cmp++; if (bus.done !== order[i] || bus.rdata !== 32'hA000_0000 + 32'(i)) begin n_bad++;
        $display("FAIL rr_done%0d: got done=%b rdata=%h want %b/%h", i, bus.done, bus.rdata, order[i], 32'hA000_0000 + 32'(i)); end
      tick();
      n_cmp++; if (bus.grant !== 4'b0000 || bus.read_q !== 1'b0) begin n_bad++;
        $display("FAIL rr_gap%0d: got grant=%b rq=%b want 0000/0", i, bus.grant, bus.read_q); end
    end
    exp_rdata = 32'hA000_0004;
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_write_wrong_hs();
    bus.addr_i[64 +: 32]  = 32'h0000_0200;
    bus.wdata_i[64 +: 32] = 32'h0000_55AA;
    bus.we  = 4'b0100;
    bus.req = 4'b0100;
    tick();
    n_cmp++; if (bus.write_q !== 1'b1 || bus.read_q !== 1'b0 || bus.grant !== 4'b0100) begin n_bad++;
      $display("FAIL wr_start: got wq=%b rq=%b grant=%b want 1/0/0100", bus.write_q, bus.read_q, bus.grant); end
    n_cmp++; if (bus.addr_out !== 32'h200 || bus.data_out !== 32'h55AA) begin n_bad++;
      $display("FAIL wr_bus: got addr=%h data=%h want 200/55aa", bus.addr_out, bus.data_out); end
    bus.data_in = 32'hBAD0_BAD0;
    bus.read_dn = 1'b1;
    tick();
    bus.read_dn = 1'b0;
    n_cmp++; if (bus.done !== 4'b0000 || bus.write_q !== 1'b1 || bus.data_out !== 32'h55AA) begin n_bad++;
      $display("FAIL wr_wrong_hs: got done=%b wq=%b data=%h want 0000/1/55aa", bus.done, bus.write_q, bus.data_out); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.data_out !== 32'h55AA || bus.done !== 4'b0000) begin n_bad++;
        $display("FAIL wr_hold%0d: got data=%h done=%b want 55aa/0000", i, bus.data_out, bus.done); end
    end
    bus.write_dn = 1'b1;
    tick();
    bus.write_dn = 1'b0;
    bus.req      = 4'b0000;
    n_cmp++; if (bus.done !== 4'b0100 || bus.err !== 1'b0 || bus.rdata !== exp_rdata) begin n_bad++;
      $display("FAIL wr_done: got done=%b err=%b rdata=%h want 0100/0/%h", bus.done, bus.err, bus.rdata, exp_rdata); end
    n_cmp++; if (bus.data_out !== 32'h0 || bus.write_q !== 1'b0 || bus.grant !== 4'b0000) begin n_bad++;
      $display("FAIL wr_release: got data=%h wq=%b grant=%b want 0/0/0000", bus.data_out, bus.write_q, bus.grant); end
    tick();
  endtask

  task automatic test_bus_busy();
    bus.bus_busy = 1'b1;
    bus.we  = 4'b0000;
    bus.addr_i[32 +: 32] = 32'h0000_0340;
    bus.req = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (bus.grant !== 4'b0000 || bus.read_q !== 1'b0) begin n_bad++;
        $display("FAIL busy_stall%0d: got grant=%b rq=%b want 0000/0", i, bus.grant, bus.read_q); end
    end
    bus.bus_busy = 1'b0;
    tick();
    n_cmp++; if (bus.grant !== 4'b0010 || bus.read_q !== 1'b1 || bus.addr_out !== 32'h340) begin n_bad++;
      $display("FAIL busy_release: got grant=%b rq=%b addr=%h want 0010/1/340", bus.grant, bus.read_q, bus.addr_out); end
    bus.bus_busy = 1'b1;
    tick();
    n_cmp++; if (bus.grant !== 4'b0010 || bus.read_q !== 1'b1) begin n_bad++;
      $display("FAIL busy_in_xfer: got grant=%b rq=%b want 0010/1", bus.grant, bus.read_q); end
    bus.data_in = 32'hCAFE_F00D;
    bus.read_dn = 1'b1;
    tick();
    bus.read_dn = 1'b0;
    bus.req     = 4'b0000;
    exp_rdata   = 32'hCAFE_F00D;
    n_cmp++; if (bus.done !== 4'b0010 || bus.rdata !== exp_rdata) begin n_bad++;
      $display("FAIL busy_done: got done=%b rdata=%h want 0010/%h", bus.done, bus.rdata, exp_rdata); end
    tick();
    bus.bus_busy = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.we  = 4'b0100;
    bus.req = 4'b0100;
    tick();
    n_cmp++; if (bus.write_q !== 1'b1 || bus.grant !== 4'b0100) begin n_bad++;
      $display("FAIL rstmid_start: got wq=%b grant=%b want 1/0100", bus.write_q, bus.grant); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.grant !== 4'b0000 || bus.write_q !== 1'b0 || bus.read_q !== 1'b0 || bus.done !== 4'b0000) begin n_bad++;
      $display("FAIL rstmid_abort: got grant=%b wq=%b rq=%b done=%b want 0000/0/0/0000", bus.grant, bus.write_q, bus.read_q, bus.done); end
    bus.we  = 4'b0000;
    bus.req = 4'b1111;
    tick();
    n_cmp++; if (bus.grant !== 4'b0001 || bus.read_q !== 1'b1 || bus.done !== 4'b0000) begin n_bad++;
      $display("FAIL rstmid_first: got grant=%b rq=%b done=%b want 0001/1/0000", bus.grant, bus.read_q, bus.done); end
    bus.data_in = 32'h0000_00AB;
    bus.read_dn = 1'b1;
    tick();
    bus.read_dn = 1'b0;
    bus.req     = 4'b0000;
    exp_rdata   = 32'h0000_00AB;
    n_cmp++; if (bus.done !== 4'b0001 || bus.rdata !== exp_rdata) begin n_bad++;
      $display("FAIL rstmid_done: got done=%b rdata=%h want 0001/%h", bus.done, bus.rdata, exp_rdata); end
    tick();
  endtask

`ifdef INT_BUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bus.we  = 4'b0000;
    bus.req = 4'b0001;
    bus.data_in = 32'h7777_7777;
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++; if (bus.read_q !== 1'b1 || bus.done !== 4'b0000) begin n_bad++;
        $display("FAIL to_wait%0d: got rq=%b done=%b want 1/0000", i, bus.read_q, bus.done); end
    end
    tick();
    bus.req = 4'b0000;
    n_cmp++; if (bus.done !== 4'b0001 || bus.err !== 1'b1 || bus.read_q !== 1'b0 || bus.rdata !== exp_rdata) begin n_bad++;
      $display("FAIL to_abort: got done=%b err=%b rq=%b rdata=%h want 0001/1/0/%h", bus.done, bus.err, bus.read_q, bus.rdata, exp_rdata); end
    tick();
    n_cmp++; if (bus.err !== 1'b0 || bus.done !== 4'b0000) begin n_bad++;
      $display("FAIL to_err_clear: got err=%b done=%b want 0/0000", bus.err, bus.done); end
    bus.req = 4'b0001;
    tick();
    for (int i = 0; i < 7; i++) tick();
    bus.data_in = 32'h0BAD_F00D;
    bus.read_dn = 1'b1;
    tick();
    bus.read_dn = 1'b0;
    bus.req     = 4'b0000;
    exp_rdata   = 32'h0BAD_F00D;
    n_cmp++; if (bus.done !== 4'b0001 || bus.err !== 1'b0 || bus.rdata !== exp_rdata) begin n_bad++;
      $display("FAIL to_hs_wins: got done=%b err=%b rdata=%h want 0001/0/%h", bus.done, bus.err, bus.rdata, exp_rdata); end
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_wrong_hs();
    test_bus_busy();
    test_reset_mid();
`ifdef INT_BUS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
